// File: rtl/reg_file_bypass.sv
// reg_file_bypass: 2R/1W architectural register file
// with same-cycle WB-to-ID write bypass and async clear.
module reg_file_bypass #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] SrcReg1,
  input  logic [ADDR_W-1:0] SrcReg2,
  input  logic [ADDR_W-1:0] DstReg,
  input  logic              WriteReg,
  input  logic [DATA_W-1:0] DstData,
  output logic [DATA_W-1:0] SrcData1,
  output logic [DATA_W-1:0] SrcData2
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0]   wordline;
  logic [DATA_W-1:0] mem [NREG];
  logic              wrLive;

  // one-hot wordline, gated by enable; R0 masked when hardwired
  always_comb begin
    wordline = '0;
    if (WriteReg) wordline[DstReg] = 1'b1;
    if (ZERO_REG) wordline[0] = 1'b0;
  end

  assign wrLive = |wordline;

  // register array: async clear, one-hot load on rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++)
        if (wordline[i]) mem[i] <= DstData;
    end
  end

  // read port 1: array, then bypass, then R0 and reset forcing
  always_comb begin
    SrcData1 = mem[SrcReg1];
    if (wrLive && (DstReg == SrcReg1)) SrcData1 = DstData;
    if (ZERO_REG && (SrcReg1 == '0)) SrcData1 = '0;
    if (!rst_n) SrcData1 = '0;
  end

  // read port 2: same priority as port 1
  always_comb begin
    SrcData2 = mem[SrcReg2];
    if (wrLive && (DstReg == SrcReg2)) SrcData2 = DstData;
    if (ZERO_REG && (SrcReg2 == '0)) SrcData2 = '0;
    if (!rst_n) SrcData2 = '0;
  end

endmodule

// File: tb/tb_reg_file_bypass.sv
// tb_reg_file_bypass: directed vectors, expected
// values queued and checked by a separate monitor.
module tb_reg_file_bypass;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  SrcReg1, SrcReg2, DstReg;
  logic        WriteReg;
  logic [15:0] DstData;
  logic [15:0] SrcData1, SrcData2;

  reg_file_bypass #(
    .DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
    .DstReg(DstReg), .WriteReg(WriteReg),
    .DstData(DstData),
    .SrcData1(SrcData1), .SrcData2(SrcData2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [15:0] e1;
    logic [15:0] e2;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   total = 0;
  int   bad = 0;
  int   issued = 0;
  int   checked = 0;

  // monitor: samples both ports 1ns after each request
  initial begin
    forever begin
      wait (checked != issued);
      #1;
      cur = q.pop_front();
      total++;
      if (SrcData1 !== cur.e1) begin
        bad++;
        $display("FAIL %s port1 got %h want %h",
                 cur.nm, SrcData1, cur.e1);
      end
      total++;
      if (SrcData2 !== cur.e2) begin
        bad++;
        $display("FAIL %s port2 got %h want %h",
                 cur.nm, SrcData2, cur.e2);
      end
      checked++;
    end
  end

  task automatic setIn(input logic w,
                       input logic [3:0] d,
                       input logic [15:0] dat,
                       input logic [3:0] s1,
                       input logic [3:0] s2);
    WriteReg = w;
    DstReg   = d;
    DstData  = dat;
    SrcReg1  = s1;
    SrcReg2  = s2;
  endtask

  task automatic chk(input string nm,
                     input logic [15:0] e1,
                     input logic [15:0] e2);
    exp_t e;
    e.nm = nm;
    e.e1 = e1;
    e.e2 = e2;
    q.push_back(e);
    issued++;
    for (int t = 0; t < 4 && checked != issued; t++) #1;
    if (checked != issued) begin
      bad++;
      $display("FAIL %s monitor timeout got none want sample", nm);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1);
    end
  endtask

  logic [15:0] v;

  initial begin
    rst_n = 1'b0;
    setIn(1'b1, 4'd5, 16'hBEEF, 4'd5, 4'd5);
    #1;
    chk("rst_bypass", 16'h0000, 16'h0000);
    setIn(1'b0, 4'd0, 16'h0, 4'd9, 4'd15);
    chk("rst_read", 16'h0000, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // write sweep R1..R15
    for (int k = 1; k < 16; k++) begin
      v = 16'(32'h1111 * k);
      setIn(1'b1, 4'(k), v, 4'd0, 4'd0);
      @(negedge clk);
    end
    // read sweep on both ports
    for (int k = 0; k < 16; k++) begin
      v = 16'(32'h1111 * k);
      setIn(1'b0, 4'd0, 16'h0, 4'(k), 4'(k));
      chk("sweep", v, v);
      @(negedge clk);
    end
    setIn(1'b0, 4'd0, 16'h0, 4'd2, 4'd14);
    chk("sweep_mix", 16'h2222, 16'hEEEE);

    // async pulse with no clock edge
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      setIn(1'b0, 4'd0, 16'h0, 4'(k), 4'(15 - k));
      chk("async_clr", 16'h0000, 16'h0000);
    end

    // preload R3, R5, R6
    @(negedge clk);
    setIn(1'b1, 4'd3, 16'h3333, 4'd0, 4'd0);
    @(negedge clk);
    setIn(1'b1, 4'd5, 16'h0005, 4'd0, 4'd0);
    @(negedge clk);
    setIn(1'b1, 4'd6, 16'h6666, 4'd5, 4'd0);
    @(negedge clk);
    setIn(1'b0, 4'd0, 16'h0, 4'd5, 4'd6);
    chk("preload", 16'h0005, 16'h6666);

    // same-cycle bypass on both ports
    @(negedge clk);
    setIn(1'b1, 4'd5, 16'hBEEF, 4'd5, 4'd5);
    chk("bypass_both", 16'hBEEF, 16'hBEEF);
    setIn(1'b1, 4'd5, 16'hBEEF, 4'd5, 4'd6);
    chk("bypass_p1", 16'hBEEF, 16'h6666);
    setIn(1'b1, 4'd5, 16'hBEEF, 4'd6, 4'd5);
    chk("bypass_p2", 16'h6666, 16'hBEEF);
    @(negedge clk);
    setIn(1'b0, 4'd5, 16'h0, 4'd5, 4'd5);
    chk("bypass_after", 16'hBEEF, 16'hBEEF);

    // R0 write dropped, no bypass
    @(negedge clk);
    setIn(1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0);
    chk("r0_same", 16'h0000, 16'h0000);
    @(negedge clk);
    setIn(1'b0, 4'd0, 16'h0, 4'd0, 4'd5);
    chk("r0_after", 16'h0000, 16'hBEEF);

    // write disable
    @(negedge clk);
    setIn(1'b0, 4'd3, 16'hAAAA, 4'd3, 4'd3);
    chk("wdis_before", 16'h3333, 16'h3333);
    @(negedge clk);
    chk("wdis_after", 16'h3333, 16'h3333);
    setIn(1'b0, 4'bxxxx, 16'hAAAA, 4'd3, 4'd6);
    @(negedge clk);
    chk("wdis_xaddr", 16'h3333, 16'h6666);

    // reset coincident with a write to R7
    @(negedge clk);
    setIn(1'b1, 4'd7, 16'h1234, 4'd7, 4'd7);
    chk("rvw_pre", 16'h1234, 16'h1234);
    #1 rst_n = 1'b0;
    chk("rvw_during", 16'h0000, 16'h0000);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    setIn(1'b0, 4'd0, 16'h0, 4'd7, 4'd5);
    chk("rvw_after", 16'h0000, 16'h0000);

    // read-after-write across cycles
    @(negedge clk);
    setIn(1'b1, 4'd9, 16'hC0DE, 4'd9, 4'd1);
    @(negedge clk);
    setIn(1'b0, 4'd0, 16'h0, 4'd1, 4'd9);
    chk("raw_next", 16'h0000, 16'hC0DE);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
